div_core_arbiter: RTL and testbench

// - Shares one iterative unsigned divider core (start/done, quotient/remainder/divisor_is_zero) among NUM_REQ requesters.
// - Typical requesters: the integer div unit and an FP mantissa divider.
// - Round-robin grant, held from core start until the requester acks the result.
// - Registered result holding, per-requester flush with drain, optional last-result cache.

---
 rtl/div_core_arbiter.sv | 125 ++++++++++++
 tb/tb_div_core_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_core_arbiter.sv
// div_core_arbiter: round-robin sharing of one iterative unsigned divider core among NUM_REQ requesters
// Optional feature: define DIV_ARB_RESULT_CACHE_EN to answer a repeat of the last completed operands
// from a one-entry cache without starting the core.
// Ports: clk, rst (async, active-low);
//        req_valid/req_ready/req_dividend/req_divisor/req_flush - per-requester request side;
//        resp_valid/resp_ack/resp_quotient/resp_remainder/resp_div_zero - result held for the owner;
//        core_start/core_dividend/core_divisor/core_done/core_quotient/core_remainder/core_div_zero - core side.
module div_core_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_flush,
   output logic [NUM_REQ-1:0]            resp_valid,
   input  logic [NUM_REQ-1:0]            resp_ack,
   output logic [DATA_WIDTH-1:0]         resp_quotient,
   output logic [DATA_WIDTH-1:0]         resp_remainder,
   output logic                          resp_div_zero,
   output logic                          core_start,
   output logic [DATA_WIDTH-1:0]         core_dividend,
   output logic [DATA_WIDTH-1:0]         core_divisor,
   input  logic                          core_done,
   input  logic [DATA_WIDTH-1:0]         core_quotient,
   input  logic [DATA_WIDTH-1:0]         core_remainder,
   input  logic                          core_div_zero
);
   localparam int IW = $clog2(NUM_REQ);
   typedef enum logic [2:0] {IDLE, START, BUSY, HOLD, DRAIN} state_t;
   state_t                state, state_nxt;
   logic [IW-1:0]         rr_ptr, owner, grant;
   logic                  grant_vld, hit, flush_own, ack_own, accept, capture;
   logic [DATA_WIDTH-1:0] g_dividend, g_divisor;
   // first valid requester at or after the round-robin pointer, wrapping
   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (!grant_vld && req_valid[IW'((int'(rr_ptr) + k) % NUM_REQ)]) begin
            grant_vld = 1'b1;
            grant     = IW'((int'(rr_ptr) + k) % NUM_REQ);
         end
   end
   assign g_dividend = req_dividend[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
   assign g_divisor  = req_divisor[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
   assign flush_own  = req_flush[owner];
   assign ack_own    = resp_ack[owner];
   assign accept     = state == IDLE && grant_vld;
   // a flush landing together with core_done discards the result
   assign capture    = state == BUSY && core_done && !flush_own;
   // ready is gated by rst so it reads 0 while reset is held
   assign req_ready  = (rst && accept) ? NUM_REQ'(1) << grant : '0;
   assign resp_valid = state == HOLD ? NUM_REQ'(1) << owner : '0;
   assign core_start = state == START;
`ifdef DIV_ARB_RESULT_CACHE_EN
   logic                  cache_vld, cache_zero;
   logic [DATA_WIDTH-1:0] cache_dividend, cache_divisor, cache_quotient, cache_remainder;
   assign hit = cache_vld && cache_dividend == g_dividend && cache_divisor == g_divisor;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         cache_vld       <= 1'b0;
         cache_dividend  <= '0;
         cache_divisor   <= '0;
         cache_quotient  <= '0;
         cache_remainder <= '0;
         cache_zero      <= 1'b0;
      end else if (capture) begin
         cache_vld       <= 1'b1;
         cache_dividend  <= core_dividend;
         cache_divisor   <= core_divisor;
         cache_quotient  <= core_quotient;
         cache_remainder <= core_remainder;
         cache_zero      <= core_div_zero;
      end
`else
   assign hit = 1'b0;
`endif
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_vld) state_nxt = hit ? HOLD : START;
         START:   state_nxt = flush_own ? DRAIN : BUSY;
         BUSY:    if (core_done) state_nxt = flush_own ? IDLE : HOLD;
                  else if (flush_own) state_nxt = DRAIN;
         HOLD:    if (ack_own || flush_own) state_nxt = IDLE;
         DRAIN:   if (core_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         owner          <= '0;
         core_dividend  <= '0;
         core_divisor   <= '0;
         resp_quotient  <= '0;
         resp_remainder <= '0;
         resp_div_zero  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            owner         <= grant;
            rr_ptr        <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
            core_dividend <= g_dividend;
            core_divisor  <= g_divisor;
         end
         if (capture) begin
            resp_quotient  <= core_quotient;
            resp_remainder <= core_remainder;
            resp_div_zero  <= core_div_zero;
         end
`ifdef DIV_ARB_RESULT_CACHE_EN
         else if (accept && hit) begin
            resp_quotient  <= cache_quotient;
            resp_remainder <= cache_remainder;
            resp_div_zero  <= cache_zero;
         end
`endif
      end
endmodule

// File: tb/tb_div_core_arbiter.sv
// tb_div_core_arbiter: directed and randomized checks of div_core_arbiter against a transaction-level model
// The bench also plays the divider core, answering core_start after a random latency.
module tb_div_core_arbiter;
   localparam int N = 3;
   localparam int W = 32;
`ifdef DIV_ARB_RESULT_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif
   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid, req_ready, req_flush, resp_valid, resp_ack;
   logic [N*W-1:0] req_dividend, req_divisor;
   logic [W-1:0]   resp_quotient, resp_remainder, core_dividend, core_divisor, core_quotient, core_remainder;
   logic           resp_div_zero, core_start, core_done, core_div_zero;
   div_core_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
      .req_ready(req_ready), .req_flush(req_flush),
      .resp_valid(resp_valid), .resp_ack(resp_ack),
      .resp_quotient(resp_quotient), .resp_remainder(resp_remainder), .resp_div_zero(resp_div_zero),
      .core_start(core_start), .core_dividend(core_dividend), .core_divisor(core_divisor),
      .core_done(core_done), .core_quotient(core_quotient), .core_remainder(core_remainder),
      .core_div_zero(core_div_zero)
   );
   always #5 clk = ~clk;
   int n_tot = 0;
   int n_pass = 0;
   // model: phase 0 free, 1 start pulse, 2 computing, 3 result held, 4 draining a flushed op
   int         ph, rr, own, g_last;
   logic [W-1:0] ma, mb, mq, mr, ca, cb, cq, cr;
   logic       mz, cz, cv;
   // bench-side divider core
   logic       cbusy;
   int         ccnt;
   logic [W-1:0] cdv, cds;
   logic       pend [N];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_tot++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
   endtask
   function automatic int pick(input logic [N-1:0] v, input int from);
      for (int k = 0; k < N; k++) if (v[(from + k) % N]) return (from + k) % N;
      return -1;
   endfunction
   function automatic logic [W-1:0] q_of(input logic [W-1:0] a, input logic [W-1:0] b);
      return b == 0 ? '1 : a / b;
   endfunction
   function automatic logic [W-1:0] r_of(input logic [W-1:0] a, input logic [W-1:0] b);
      return b == 0 ? a : a % b;
   endfunction
   task automatic model_reset();
      ph = 0; rr = 0; own = 0; ma = '0; mb = '0; mq = '0; mr = '0; mz = 1'b0;
      cv = 1'b0; cbusy = 1'b0; ccnt = 0; g_last = -1;
   endtask
   // one clock: entered just after a negedge with request inputs set; leaves at the next negedge
   task automatic tick();
      int           g;
      logic [N-1:0] er;
      logic         fl, ak;
      core_done = 1'b0;
      core_quotient = $urandom;
      core_remainder = $urandom;
      core_div_zero = 1'($urandom);
      if (cbusy && ccnt == 1) begin
         core_done = 1'b1;
         core_quotient = q_of(cdv, cds);
         core_remainder = r_of(cdv, cds);
         core_div_zero = cds == 0;
      end else if (!cbusy && $urandom_range(15) == 0) core_done = 1'b1;
      #1;
      g = ph == 0 ? pick(req_valid, rr) : -1;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", req_ready, er);
      chk("core_start", core_start, ph == 1);
      er = '0;
      if (ph == 3) er[own] = 1'b1;
      chk("resp_valid", resp_valid, er);
      if (ph == 1 || ph == 2 || ph == 4) begin
         chk("core_dividend", core_dividend, ma);
         chk("core_divisor", core_divisor, mb);
      end
      if (ph == 3) begin
         chk("resp_quotient", resp_quotient, mq);
         chk("resp_remainder", resp_remainder, mr);
         chk("resp_div_zero", resp_div_zero, mz);
      end
      fl = req_flush[own];
      ak = resp_ack[own];
      g_last = g;
      case (ph)
         0: if (g >= 0) begin
               own = g;
               ma = req_dividend[g*W +: W];
               mb = req_divisor[g*W +: W];
               rr = (g + 1) % N;
               if (CACHE && cv && ca == ma && cb == mb) begin
                  mq = cq; mr = cr; mz = cz; ph = 3;
               end else ph = 1;
            end
         1: ph = fl ? 4 : 2;
         2: if (core_done) begin
               if (fl) ph = 0;
               else begin
                  mq = q_of(ma, mb); mr = r_of(ma, mb); mz = mb == 0; ph = 3;
                  cv = 1'b1; ca = ma; cb = mb; cq = mq; cr = mr; cz = mz;
               end
            end else if (fl) ph = 4;
         3: if (fl || ak) ph = 0;
         default: if (core_done) ph = 0;
      endcase
      if (cbusy && core_done) cbusy = 1'b0;
      else if (cbusy) ccnt--;
      if (core_start) begin
         cbusy = 1'b1;
         ccnt = $urandom_range(1, 4);
         cdv = core_dividend;
         cds = core_divisor;
      end
      @(negedge clk);
   endtask
   task automatic wait_resp();
      for (int k = 0; k < 20 && resp_valid == 0; k++) tick();
   endtask
   task automatic ack(input int i);
      resp_ack = '0;
      resp_ack[i] = 1'b1;
      tick();
      resp_ack = '0;
   endtask
   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_dividend[i*W +: W] = a;
      req_divisor[i*W +: W] = b;
   endtask
   task automatic check_zero(input string tag);
      chk({tag, "_req_ready"}, req_ready, 0);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_core_start"}, core_start, 0);
      chk({tag, "_resp_q"}, resp_quotient, 0);
      chk({tag, "_resp_r"}, resp_remainder, 0);
      chk({tag, "_resp_z"}, resp_div_zero, 0);
      chk({tag, "_core_dvd"}, core_dividend, 0);
      chk({tag, "_core_dvs"}, core_divisor, 0);
   endtask
   // assert reset between edges and expect every output to clear at once
   task automatic reset_mid();
      #2;
      rst = 1'b0;
      core_done = 1'b0;
      #1;
      check_zero("midrst");
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask
   initial begin
      int  k;
      logic saw, busy_at_grant;
      logic [W-1:0] a, b;
      rst = 1'b0;
      req_valid = '0; req_flush = '0; resp_ack = '0; req_dividend = '0; req_divisor = '0;
      core_done = 1'b0; core_quotient = '0; core_remainder = '0; core_div_zero = 1'b0;
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      model_reset();
      #3;
      check_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      // two requesters at once after reset: req0 first, then req1 after a bubble
      set_op(0, 100, 7);
      set_op(1, 9, 2);
      req_valid = 3'b011;
      tick();
      chk("t2_first_grant", g_last, 0);
      req_valid = 3'b010;
      chk("t1_start", core_start, 1);
      chk("t1_core_dvd", core_dividend, 100);
      wait_resp();
      chk("t1_resp_valid", resp_valid, 3'b001);
      chk("t1_q", resp_quotient, 14);
      chk("t1_r", resp_remainder, 2);
      chk("t1_z", resp_div_zero, 0);
      ack(0);
      chk("t1_after_ack", resp_valid, 0);
      tick();
      chk("t2_second_grant", g_last, 1);
      req_valid = '0;
      wait_resp();
      chk("t2_resp_valid", resp_valid, 3'b010);
      chk("t2_q", resp_quotient, 4);
      chk("t2_r", resp_remainder, 1);
      ack(1);
      // divide by zero on requester 2
      set_op(2, 5, 0);
      req_valid = 3'b100;
      tick();
      chk("t3_grant", g_last, 2);
      req_valid = '0;
      wait_resp();
      chk("t3_resp_valid", resp_valid, 3'b100);
      chk("t3_q", resp_quotient, 32'hFFFF_FFFF);
      chk("t3_r", resp_remainder, 5);
      chk("t3_z", resp_div_zero, 1);
      ack(2);
      // same operands twice: the repeat is served from the cache when it is built in
      for (int rep = 0; rep < 2; rep++) begin
         set_op(0, 100, 7);
         req_valid = 3'b001;
         tick();
         req_valid = '0;
         chk("t6_start", core_start, rep == 0 || !CACHE);
         chk("t6_early_resp", resp_valid, (rep == 1 && CACHE) ? 3'b001 : 3'b000);
         wait_resp();
         chk("t6_q", resp_quotient, 14);
         chk("t6_r", resp_remainder, 2);
         ack(0);
      end
      // flush the owner while the core runs; the waiting requester is granted only after the drain
      set_op(0, 50, 5);
      req_valid = 3'b001;
      tick();
      set_op(1, 77, 7);
      req_valid = 3'b010;
      req_flush = 3'b001;
      tick();
      req_flush = '0;
      saw = 1'b0;
      busy_at_grant = 1'b0;
      for (k = 0; k < 20 && g_last != 1; k++) begin
         saw |= resp_valid != 0;
         busy_at_grant = cbusy;
         tick();
      end
      chk("t4_grant", g_last, 1);
      chk("t4_no_resp", saw, 0);
      chk("t4_core_idle_at_grant", busy_at_grant, 0);
      req_valid = '0;
      wait_resp();
      chk("t4_resp_valid", resp_valid, 3'b010);
      chk("t4_q", resp_quotient, 11);
      chk("t4_r", resp_remainder, 0);
      ack(1);
      // reset while the core is busy, then a clean operation
      set_op(0, 123, 4);
      req_valid = 3'b001;
      tick();
      req_valid = '0;
      tick();
      reset_mid();
      set_op(0, 1000, 10);
      req_valid = 3'b001;
      tick();
      chk("t5_grant", g_last, 0);
      req_valid = '0;
      wait_resp();
      chk("t5_resp_valid", resp_valid, 3'b001);
      chk("t5_q", resp_quotient, 100);
      chk("t5_r", resp_remainder, 0);
      ack(0);
      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(2) == 0) begin
               pend[i] = 1'b1;
               a = $urandom;
               b = $urandom;
               case ($urandom_range(5))
                  0: b = '0;
                  1: b = $urandom_range(1, 9);
                  2, 3: begin a = 100; b = 7; end
                  4: a = $urandom_range(0, 50);
                  default: ;
               endcase
               set_op(i, a, b);
            end
            req_valid[i] = pend[i];
            req_flush[i] = $urandom_range(19) == 0;
         end
         resp_ack = N'($urandom);
         tick();
         if (g_last >= 0) pend[g_last] = 1'b0;
         if ($urandom_range(299) == 0) reset_mid();
      end
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
